// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit shift-add multiplier: operand width and controller states.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/shift_add_controller_iter_counter.sv
// Iteration counter: clear, increment, saturate at WIDTH; o_tc flags the final iteration.
// Count updates one cycle after i_clear/i_inc; no backpressure.
module iter_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_inc,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CW'(WIDTH))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_add_controller.sv
// Shift-add multiplier sequencer: start -> load, WIDTH add/shift pairs, done pulse (2*WIDTH+2 cycles).
// start is only honoured in IDLE/DONE; held start chains operations with no idle gap.
module shift_add_controller
    import mult_pkg::*;
#(
    parameter  int WIDTH = MULT_WIDTH,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_q0,
    output logic          o_load,
    output logic          o_add,
    output logic          o_shift,
    output logic          o_ready,
    output logic          o_done,
    output logic [CW-1:0] o_bit_count
);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    logic        w_clear;
    logic        w_inc;
    logic        w_tc;

    iter_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .i_inc   (w_inc),
        .o_count (o_bit_count),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = IDLE;
        o_load  = 1'b0;
        o_add   = 1'b0;
        o_shift = 1'b0;
        o_ready = 1'b0;
        o_done  = 1'b0;
        w_clear = 1'b0;
        w_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                w_next  = i_start ? LOAD : IDLE;
            end
            LOAD: begin
                o_load  = 1'b1;
                w_clear = 1'b1;
                w_next  = ADD;
            end
            ADD: begin
                // Cycle is spent even when q0=0 so latency is operand-independent.
                o_add  = i_q0;
                w_next = SHIFT;
            end
            SHIFT: begin
                o_shift = 1'b1;
                w_inc   = 1'b1;
                w_next  = w_tc ? DONE : ADD;
            end
            DONE: begin
                o_done = 1'b1;
                w_next = i_start ? LOAD : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_add_controller.sv
// Directed bench for shift_add_controller with a behavioural C/A/Q register and adder around it.
module tb_shift_add_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       q0;
    logic       load, add, shift, ready, done;
    logic [3:0] bc;

    logic [7:0] mcand, mplier;
    logic [7:0] r_a, r_q;
    logic       r_c;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    shift_add_controller dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_q0        (q0),
        .o_load      (load),
        .o_add       (add),
        .o_shift     (shift),
        .o_ready     (ready),
        .o_done      (done),
        .o_bit_count (bc)
    );

    // Datapath: load clears C,A and loads Q; add stores C,Sum; shift moves C,A,Q right.
    always @(posedge clk) begin
        if (load) begin
            r_c <= 1'b0;
            r_a <= 8'd0;
            r_q <= mplier;
        end else if (add) begin
            {r_c, r_a} <= {1'b0, r_a} + {1'b0, mcand};
        end else if (shift) begin
            {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[7:1]};
        end
    end
    assign q0 = r_q[0];

    always @(negedge clk) begin
        if (chk_en && rst_n === 1'b1) begin
            n_cmp++;
            if (({2'b00, load} + {2'b00, add} + {2'b00, shift}) > 3'd1) begin
                n_err++;
                $display("FAIL strobe_exclusive: load=%b add=%b shift=%b, at most one high required", load, add, shift);
            end
            if (done && prev_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_pulse: done high on two consecutive cycles, single-cycle pulse required");
            end
            prev_done <= done;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one multiplication from IDLE; pulse_cyc (>=1) raises start for one cycle mid-operation.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int pulse_cyc,
                         output int done_cyc, output logic [7:0] amask, output logic [15:0] prod,
                         output logic ld1, output logic rdy_after, output logic [3:0] bc_done);
        int cyc;
        mcand = a;
        mplier = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        ld1 = load;
        cyc = 1;
        amask = 8'd0;
        done_cyc = -1;
        prod = 16'd0;
        bc_done = 4'd0;
        while (cyc < 40 && done_cyc < 0) begin
            if (cyc == pulse_cyc) start = 1'b1;
            else if (cyc == pulse_cyc + 1) start = 1'b0;
            if (add === 1'b1 && cyc >= 2 && cyc <= 17) amask[(cyc - 2) / 2] = 1'b1;
            if (done === 1'b1) begin
                done_cyc = cyc;
                prod = {r_a, r_q};
                bc_done = bc;
            end else begin
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        tick();
        rdy_after = ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        mcand = 8'd0;
        mplier = 8'd0;
        #2;
        n_cmp++;
        if ({load, add, shift, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_strobes: load/add/shift/done=%b, required 0000", {load, add, shift, done});
        end
        n_cmp++;
        if (ready !== 1'b1 || bc !== 4'd0) begin
            n_err++;
            $display("FAIL reset_ready_count: ready=%b bit_count=%0d, required ready=1 bit_count=0", ready, bc);
        end
        #10 rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        mcand = 8'd13;
        mplier = 8'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (bc !== 4'd2) begin
            n_err++;
            $display("FAIL midrun_count: bit_count=%0d at cycle 6, required 2", bc);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({load, add, shift, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL midrun_reset_strobes: load/add/shift/done=%b, required 0000", {load, add, shift, done});
        end
        n_cmp++;
        if (ready !== 1'b1 || bc !== 4'd0) begin
            n_err++;
            $display("FAIL midrun_reset_ready: ready=%b bit_count=%0d, required ready=1 bit_count=0", ready, bc);
        end
        #2 rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (ready !== 1'b1 || load !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_idle: ready=%b load=%b, required ready=1 load=0", ready, load);
        end
    endtask

    task automatic test_single;
        int dc;
        logic [7:0] am;
        logic [15:0] p;
        logic l1, ra;
        logic [3:0] bd;
        do_op(8'd13, 8'd11, -1, dc, am, p, l1, ra, bd);
        n_cmp++;
        if (l1 !== 1'b1) begin
            n_err++;
            $display("FAIL single_load: load=%b in cycle 1, required 1", l1);
        end
        n_cmp++;
        if (am !== 8'b0000_1011) begin
            n_err++;
            $display("FAIL single_addmask: got %b, required 00001011", am);
        end
        n_cmp++;
        if (dc != 18) begin
            n_err++;
            $display("FAIL single_done_cycle: got %0d, required 18", dc);
        end
        n_cmp++;
        if (p !== 16'd143) begin
            n_err++;
            $display("FAIL single_product: got %0d, required 143", p);
        end
        n_cmp++;
        if (bd !== 4'd8 || ra !== 1'b1) begin
            n_err++;
            $display("FAIL single_done_state: bit_count=%0d ready_after=%b, required 8 and 1", bd, ra);
        end
        tick();
        n_cmp++;
        if (bc !== 4'd8) begin
            n_err++;
            $display("FAIL idle_count_hold: bit_count=%0d in IDLE, required 8", bc);
        end
    endtask

    task automatic test_edges;
        logic [7:0]  ta [3] = '{8'd0,   8'd255,    8'd255};
        logic [7:0]  tb [3] = '{8'd255, 8'd255,    8'd0};
        logic [7:0]  tm [3] = '{8'hFF,  8'hFF,     8'h00};
        logic [15:0] tp [3] = '{16'd0,  16'hFE01,  16'd0};
        for (int i = 0; i < 3; i++) begin
            int dc;
            logic [7:0] am;
            logic [15:0] p;
            logic l1, ra;
            logic [3:0] bd;
            do_op(ta[i], tb[i], -1, dc, am, p, l1, ra, bd);
            n_cmp++;
            if (am !== tm[i]) begin
                n_err++;
                $display("FAIL edge%0d_addmask: got %b, required %b", i, am, tm[i]);
            end
            n_cmp++;
            if (p !== tp[i]) begin
                n_err++;
                $display("FAIL edge%0d_product: got %h, required %h", i, p, tp[i]);
            end
            n_cmp++;
            if (dc != 18) begin
                n_err++;
                $display("FAIL edge%0d_done_cycle: got %0d, required 18", i, dc);
            end
        end
    endtask

    task automatic test_ignored_start;
        int dc;
        logic [7:0] am;
        logic [15:0] p;
        logic l1, ra;
        logic [3:0] bd;
        do_op(8'd13, 8'd11, 11, dc, am, p, l1, ra, bd);
        n_cmp++;
        if (dc != 18 || p !== 16'd143) begin
            n_err++;
            $display("FAIL ignored_start_done: cycle=%0d product=%0d, required 18 and 143", dc, p);
        end
        n_cmp++;
        if (ra !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_start_ready: ready=%b in cycle 19, required 1", ra);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, d1, d2;
        logic [15:0] p1, p2;
        logic rdy_d1, ld_next, rdy_next;
        mcand = 8'd6;
        mplier = 8'd7;
        start = 1'b1;
        tick();
        cyc = 1;
        d1 = -1;
        d2 = -1;
        p1 = 16'd0;
        p2 = 16'd0;
        rdy_d1 = 1'b1;
        ld_next = 1'b0;
        rdy_next = 1'b1;
        while (cyc < 60 && d2 < 0) begin
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    p1 = {r_a, r_q};
                    rdy_d1 = ready;
                    mcand = 8'd9;
                    mplier = 8'd9;
                end else begin
                    d2 = cyc;
                    p2 = {r_a, r_q};
                    start = 1'b0;
                end
            end
            if (d2 < 0) begin
                tick();
                cyc++;
                if (d1 >= 0 && cyc == d1 + 1) begin
                    ld_next = load;
                    rdy_next = ready;
                end
            end
        end
        start = 1'b0;
        tick();
        n_cmp++;
        if (d1 != 18 || p1 !== 16'd42) begin
            n_err++;
            $display("FAIL b2b_first: done cycle=%0d product=%0d, required 18 and 42", d1, p1);
        end
        n_cmp++;
        if (ld_next !== 1'b1 || rdy_next !== 1'b0 || rdy_d1 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_chain: load=%b ready=%b after done, ready=%b in done; required 1,0,0", ld_next, rdy_next, rdy_d1);
        end
        n_cmp++;
        if (d2 != 36 || p2 !== 16'd81) begin
            n_err++;
            $display("FAIL b2b_second: done cycle=%0d product=%0d, required 36 and 81", d2, p2);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_return_idle: ready=%b, required 1", ready);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            int dc;
            logic [7:0] am, a, b;
            logic [15:0] p;
            logic l1, ra;
            logic [3:0] bd;
            a = 8'($urandom);
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            do_op(a, b, int'($urandom_range(2, 17)), dc, am, p, l1, ra, bd);
            n_cmp++;
            if (p !== 16'(a) * 16'(b) || dc != 18) begin
                n_err++;
                $display("FAIL random%0d: %0d x %0d product=%0d done cycle=%0d, required %0d at 18",
                         i, a, b, p, dc, 16'(a) * 16'(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_edges();
        test_ignored_start();
        test_back_to_back();
        test_random();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
